// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow EX/MEM/WB pipeline giving load-use stall, branch flush and halt drain control.
// Define HAZARD_SCOREBOARD_STATS_EN to add saturating StallCount/FlushCount outputs.
module hazard_scoreboard (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ID_Valid,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_RegWre,
    input  logic [4:0]  ID_WriteReg,
    input  logic        ID_MemRead,
    input  logic        ID_Halt,
    input  logic        EX_BranchTaken,
    output logic        PCWre,
    output logic        IF_ID_Wre,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        Halted,
    output logic        MEM_RegWre,
    output logic [4:0]  MEM_WriteReg,
    output logic        WB_RegWre,
    output logic [4:0]  WB_WriteReg
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    typedef struct packed {
        logic       v;
        logic       rw;
        logic [4:0] wr;
        logic       mr;
    } slot_t;

    state_t     state, state_nx;
    slot_t      ex, mem, wb, ex_nx;
    logic [1:0] cnt, cnt_nx;
    logic       run, load_use, branch, stall, halt_go;

    always_comb begin
        run      = state == RUN;
        load_use = ID_Valid && ex.v && ex.mr && ex.rw && ex.wr != 5'd0 &&
                   ((ID_UsesRs && ID_rs == ex.wr) || (ID_UsesRt && ID_rt == ex.wr));
        branch   = run && EX_BranchTaken;
        stall    = run && load_use && !branch;
        halt_go  = run && ID_Valid && ID_Halt && !stall && !branch;
        state_nx = state;
        cnt_nx   = cnt;
        ex_nx    = '0;
        case (state)
            RUN: begin
                if (halt_go) begin
                    state_nx = DRAIN;
                    cnt_nx   = 2'd3;
                end else if (!stall && !branch)
                    ex_nx = {ID_Valid, ID_RegWre, ID_WriteReg, ID_MemRead};
            end
            DRAIN: begin
                cnt_nx   = cnt - 2'd1;
                state_nx = cnt == 2'd1 ? HALTED : DRAIN;
            end
            default: ;
        endcase
        // flushes are gated by Reset so a live branch input cannot leak out during reset
        PCWre       = run && !stall;
        IF_ID_Wre   = run && !stall;
        IF_ID_Flush = Reset && branch;
        ID_EX_Flush = Reset && (branch || stall);
        Halted      = state == HALTED;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= RUN;
            cnt   <= 2'd0;
            ex    <= '0;
            mem   <= '0;
            wb    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ex    <= ex_nx;
            mem   <= ex;
            wb    <= mem;
        end
    end

    assign MEM_RegWre   = mem.v && mem.rw;
    assign MEM_WriteReg = mem.wr;
    assign WB_RegWre    = wb.v && wb.rw;
    assign WB_WriteReg  = wb.wr;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall && StallCount != '1)
                StallCount <= StallCount + 32'd1;
            if (branch && FlushCount != '1)
                FlushCount <= FlushCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed literal scenarios plus randomized traffic checked each cycle against an instruction-level model.
module tb_hazard_scoreboard;
    logic       CLK = 1'b0, Reset = 1'b0;
    logic       ID_Valid = 0, ID_UsesRs = 0, ID_UsesRt = 0, ID_RegWre = 0, ID_MemRead = 0, ID_Halt = 0, EX_BranchTaken = 0;
    logic [4:0] ID_rs = 0, ID_rt = 0, ID_WriteReg = 0;
    logic       PCWre, IF_ID_Wre, IF_ID_Flush, ID_EX_Flush, Halted, MEM_RegWre, WB_RegWre;
    logic [4:0] MEM_WriteReg, WB_WriteReg;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] StallCount, FlushCount;
`endif

    hazard_scoreboard dut (
        .CLK(CLK), .Reset(Reset), .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_RegWre(ID_RegWre),
        .ID_WriteReg(ID_WriteReg), .ID_MemRead(ID_MemRead), .ID_Halt(ID_Halt),
        .EX_BranchTaken(EX_BranchTaken), .PCWre(PCWre), .IF_ID_Wre(IF_ID_Wre),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Halted(Halted),
        .MEM_RegWre(MEM_RegWre), .MEM_WriteReg(MEM_WriteReg), .WB_RegWre(WB_RegWre),
        .WB_WriteReg(WB_WriteReg)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // instruction-level model: three in-flight instructions, index 0 is EX
    typedef struct {
        bit       v, rw, mr;
        bit [4:0] wr;
    } ins_t;
    ins_t m[3];
    int   halt_age = 0;   // 0 = running, 1..3 = draining, >=4 = halted
    int   m_stalls = 0, m_flushes = 0;

    function automatic void ctl(output bit run, output bit st, output bit br);
        bit lu;
        run = halt_age == 0;
        lu  = ID_Valid && m[0].v && m[0].mr && m[0].rw && m[0].wr != 0 &&
              ((ID_UsesRs && ID_rs == m[0].wr) || (ID_UsesRt && ID_rt == m[0].wr));
        br  = run && EX_BranchTaken;
        st  = run && lu && !br;
    endfunction

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 3; i++) m[i] = '{default: 0};
            halt_age = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            bit r, s, b, h;
            ctl(r, s, b);
            h = r && !s && !b && ID_Valid && ID_Halt;
            m[2] = m[1];
            m[1] = m[0];
            if (r && !s && !b && !h) m[0] = '{ID_Valid, ID_RegWre, ID_MemRead, ID_WriteReg};
            else m[0] = '{default: 0};
            if (s) m_stalls++;
            if (b) m_flushes++;
            if (h) halt_age = 1;
            else if (halt_age > 0 && halt_age < 1000) halt_age++;
        end
    end

    always @(negedge CLK) begin
        bit r, s, b;
        ctl(r, s, b);
        chk("PCWre", PCWre, r && !s);
        chk("IF_ID_Wre", IF_ID_Wre, r && !s);
        chk("IF_ID_Flush", IF_ID_Flush, Reset && b);
        chk("ID_EX_Flush", ID_EX_Flush, Reset && (b || s));
        chk("Halted", Halted, halt_age >= 4);
        chk("MEM_RegWre", MEM_RegWre, m[1].v && m[1].rw);
        chk("MEM_WriteReg", MEM_WriteReg, m[1].wr);
        chk("WB_RegWre", WB_RegWre, m[2].v && m[2].rw);
        chk("WB_WriteReg", WB_WriteReg, m[2].wr);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        chk("StallCount", StallCount, m_stalls);
        chk("FlushCount", FlushCount, m_flushes);
`endif
    end

    task automatic iss(bit v, bit rw, bit mr, bit [4:0] wr, bit [4:0] rs, bit [4:0] rt,
                       bit urs, bit urt, bit halt, bit br);
        ID_Valid = v; ID_RegWre = rw; ID_MemRead = mr; ID_WriteReg = wr;
        ID_rs = rs; ID_rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
        ID_Halt = halt; EX_BranchTaken = br;
        #1;
    endtask

    task automatic idle();
        iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_pulse();
        #1 Reset = 1'b0;
        #1 Reset = 1'b1;
    endtask

    initial begin
        idle();
        EX_BranchTaken = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_PCWre", PCWre, 1);
        chk("rst_IF_ID_Wre", IF_ID_Wre, 1);
        chk("rst_IF_ID_Flush", IF_ID_Flush, 0);
        chk("rst_ID_EX_Flush", ID_EX_Flush, 0);
        chk("rst_Halted", Halted, 0);
        chk("rst_MEM_RegWre", MEM_RegWre, 0);
        idle();
        Reset = 1;
        tick();
        // load-use on $8 through rs
        iss(1, 1, 1, 8, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 1, 0, 10, 8, 2, 1, 0, 0, 0);
        chk("lu_PCWre", PCWre, 0);
        chk("lu_IF_ID_Wre", IF_ID_Wre, 0);
        chk("lu_ID_EX_Flush", ID_EX_Flush, 1);
        chk("lu_IF_ID_Flush", IF_ID_Flush, 0);
        tick();
        chk("lu_after_PCWre", PCWre, 1);
        chk("lu_load_in_MEM", MEM_WriteReg, 8);
        tick(); idle();
        chk("lu_bubble_MEM", MEM_RegWre, 0);
        chk("lu_WB_WriteReg", WB_WriteReg, 8);
        chk("lu_WB_RegWre", WB_RegWre, 1);
        tick();
        // $0 never matches; unused rt never matches
        iss(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
        chk("r0_no_stall", PCWre, 1);
        tick();
        iss(1, 1, 1, 9, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 1, 0, 1, 1, 9, 1, 0, 0, 0);
        chk("unused_rt_no_stall", PCWre, 1);
        tick();
        // branch wins over load-use
        iss(1, 1, 1, 8, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 1, 0, 2, 8, 0, 1, 0, 0, 1);
        chk("br_IF_ID_Flush", IF_ID_Flush, 1);
        chk("br_ID_EX_Flush", ID_EX_Flush, 1);
        chk("br_PCWre", PCWre, 1);
        chk("br_IF_ID_Wre", IF_ID_Wre, 1);
        tick(); idle();
        chk("br_no_stall_next", PCWre, 1);
        repeat (3) tick();
        // halt behind ALU writes to $3 and $4
        iss(1, 1, 0, 3, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 1, 0, 4, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("halt_issue_PCWre", PCWre, 1);
        chk("halt_issue_MEM", MEM_WriteReg, 3);
        tick(); idle();
        chk("drain_PCWre", PCWre, 0);
        chk("drain_MEM", MEM_WriteReg, 4);
        chk("drain_Halted", Halted, 0);
        tick(); tick();
        chk("drain_end_Halted", Halted, 0);
        tick();
        iss(1, 1, 0, 5, 0, 0, 0, 0, 0, 1);
        chk("halted_Halted", Halted, 1);
        chk("halted_PCWre", PCWre, 0);
        chk("halted_br_ignored", IF_ID_Flush, 0);
        tick();
        chk("halted_stays", PCWre, 0);
        idle();
        reset_pulse();
        chk("halted_reset_exit", Halted, 0);
        tick();
        // reset in the middle of a drain
        iss(1, 1, 0, 6, 0, 0, 0, 0, 0, 0); tick();
        iss(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); idle(); tick();
        #1 Reset = 1'b0;
        #1;
        chk("drain_rst_PCWre", PCWre, 1);
        chk("drain_rst_Halted", Halted, 0);
        chk("drain_rst_WB", WB_RegWre, 0);
        Reset = 1'b1;
        iss(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); tick(); idle(); tick();
        chk("post_rst_MEM_WriteReg", MEM_WriteReg, 5);
        chk("post_rst_MEM_RegWre", MEM_RegWre, 1);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        reset_pulse();
        for (int k = 0; k < 2; k++) begin
            iss(1, 1, 1, 7, 0, 0, 0, 0, 0, 0); tick();
            iss(1, 0, 0, 0, 0, 7, 0, 1, 0, 0); tick(); tick();
        end
        repeat (3) begin
            iss(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        end
        idle();
        chk("stats_StallCount", StallCount, 2);
        chk("stats_FlushCount", FlushCount, 3);
`endif
        // randomized traffic on a small register set to provoke matches
        for (int n = 0; n < 3000; n++) begin
            iss($urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
                5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                $urandom_range(1), $urandom_range(1), $urandom_range(39) == 0,
                $urandom_range(7) == 0);
            if ($urandom_range(59) == 0) reset_pulse();
            tick();
        end
        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
